// File: rtl/alu_sequencer.sv
// Initiator-side sequencer for the 32-bit ALU: one op in flight, setup/start/wait
// handshake with a settle mask on done and a timeout, valid/ready on both sides.
module alu_sequencer #(
   parameter int width          = 32,
   parameter int setup_cycles   = 1,
   parameter int start_cycles   = 1,
   parameter int settle_cycles  = 2,
   parameter int timeout_cycles = 256
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             req_valid,
   output logic             req_ready,
   input  logic [width-1:0] req_op1,
   input  logic [width-1:0] req_op2,
   input  logic [1:0]       req_control,
   output logic             rsp_valid,
   input  logic             rsp_ready,
   output logic [width-1:0] rsp_result,
   output logic [width-1:0] rsp_extra,
   output logic [1:0]       rsp_control,
   output logic             rsp_timeout,
   output logic             busy,
   output logic [width-1:0] alu_op1,
   output logic [width-1:0] alu_op2,
   output logic [1:0]       alu_control,
   output logic             alu_enable,
   output logic             alu_start,
   input  logic [width-1:0] alu_result,
   input  logic [width-1:0] alu_extra,
   input  logic             alu_done
);

   typedef enum logic [2:0] {IDLE, SETUP, START, WAIT, RESP} state_t;

   // One shared counter serves every timed state, so size it for the longest.
   localparam int CW = $clog2(timeout_cycles + setup_cycles + start_cycles + 1);
   localparam logic [CW-1:0] ONE        = CW'(1);
   localparam logic [CW-1:0] SETUP_LAST = CW'(setup_cycles - 1);
   localparam logic [CW-1:0] START_LAST = CW'(start_cycles - 1);
   localparam logic [CW-1:0] SETTLE     = CW'(settle_cycles);
   localparam logic [CW-1:0] TO_LAST    = CW'(timeout_cycles - 1);

   state_t        state;
   logic [CW-1:0] cnt;
   logic          done_ok;

   // Done from the previous op may still be high early in WAIT; mask it.
   assign done_ok = (cnt >= SETTLE) && alu_done;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state       <= IDLE;
         cnt         <= '0;
         req_ready   <= 1'b1;
         rsp_valid   <= 1'b0;
         rsp_result  <= '0;
         rsp_extra   <= '0;
         rsp_control <= '0;
         rsp_timeout <= 1'b0;
         busy        <= 1'b0;
         alu_op1     <= '0;
         alu_op2     <= '0;
         alu_control <= '0;
         alu_enable  <= 1'b0;
         alu_start   <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (req_valid) begin
                  alu_op1     <= req_op1;
                  alu_op2     <= req_op2;
                  alu_control <= req_control;
                  alu_enable  <= 1'b1;
                  req_ready   <= 1'b0;
                  busy        <= 1'b1;
                  cnt         <= '0;
                  state       <= SETUP;
               end
            end
            SETUP: begin
               if (cnt == SETUP_LAST) begin
                  cnt       <= '0;
                  alu_start <= 1'b1;
                  state     <= START;
               end else begin
                  cnt <= cnt + ONE;
               end
            end
            START: begin
               if (cnt == START_LAST) begin
                  cnt       <= '0;
                  alu_start <= 1'b0;
                  state     <= WAIT;
               end else begin
                  cnt <= cnt + ONE;
               end
            end
            WAIT: begin
               // On timeout the result/extra are captured anyway; rsp_timeout flags them.
               if (done_ok || cnt == TO_LAST) begin
                  rsp_result  <= alu_result;
                  rsp_extra   <= alu_extra;
                  rsp_control <= alu_control;
                  rsp_timeout <= !done_ok;
                  rsp_valid   <= 1'b1;
                  alu_enable  <= 1'b0;
                  cnt         <= '0;
                  state       <= RESP;
               end else begin
                  cnt <= cnt + ONE;
               end
            end
            RESP: begin
               if (rsp_ready) begin
                  rsp_valid <= 1'b0;
                  req_ready <= 1'b1;
                  busy      <= 1'b0;
                  state     <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_alu_sequencer.sv
// Directed bench for alu_sequencer with a small behavioural ALU whose done timing
// is selectable per test; results read as garbage whenever done is low.
module tb_alu_sequencer;

   logic        clock = 1'b0;
   logic        reset;
   logic        req_valid, req_ready;
   logic [31:0] req_op1, req_op2;
   logic [1:0]  req_control;
   logic        rsp_valid, rsp_ready;
   logic [31:0] rsp_result, rsp_extra;
   logic [1:0]  rsp_control;
   logic        rsp_timeout, busy;
   logic [31:0] alu_op1, alu_op2;
   logic [1:0]  alu_control;
   logic        alu_enable, alu_start;
   logic [31:0] alu_result, alu_extra;
   logic        alu_done;

   int total = 0;
   int bad   = 0;

   // 0: done always 1, 1: stale done then done 40 cycles after start, 2: never done
   int done_mode = 0;
   int kcnt      = 1000;

   always #5 clock = ~clock;

   alu_sequencer dut (
      .clock(clock), .reset(reset),
      .req_valid(req_valid), .req_ready(req_ready),
      .req_op1(req_op1), .req_op2(req_op2), .req_control(req_control),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
      .rsp_result(rsp_result), .rsp_extra(rsp_extra),
      .rsp_control(rsp_control), .rsp_timeout(rsp_timeout), .busy(busy),
      .alu_op1(alu_op1), .alu_op2(alu_op2), .alu_control(alu_control),
      .alu_enable(alu_enable), .alu_start(alu_start),
      .alu_result(alu_result), .alu_extra(alu_extra), .alu_done(alu_done)
   );

   // kcnt = 0 in the first WAIT cycle after the start strobe.
   always @(posedge clock) begin
      if (alu_start) kcnt <= 0;
      else if (kcnt < 1000) kcnt <= kcnt + 1;
   end

   assign alu_done = (done_mode == 0) ? 1'b1 :
                     (done_mode == 1) ? ((kcnt >= 39) || (kcnt < 2)) : 1'b0;

   logic [32:0] full33;
   logic [63:0] prod;
   always_comb begin
      full33     = '0;
      prod       = '0;
      alu_result = '0;
      alu_extra  = '0;
      case (alu_control)
         2'd0: begin
            full33     = {1'b0, alu_op1} + {1'b0, alu_op2};
            alu_result = full33[31:0];
            alu_extra  = {31'b0, full33[32]};
         end
         2'd1: begin
            full33     = {1'b0, alu_op1} + {1'b0, ~alu_op2} + 33'd1;
            alu_result = full33[31:0];
            alu_extra  = {31'b0, full33[32]};
         end
         2'd2: begin
            prod       = {32'b0, alu_op1} * {32'b0, alu_op2};
            alu_result = prod[31:0];
            alu_extra  = prod[63:32];
         end
         default: begin
            if (alu_op2 != 0) begin
               alu_result = alu_op1 / alu_op2;
               alu_extra  = alu_op1 % alu_op2;
            end
         end
      endcase
      if (!alu_done) begin
         alu_result = 32'hDEAD_BEEF;
         alu_extra  = 32'hDEAD_BEEF;
      end
   end

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Present a request while idle; returns #1 after the accept edge (cycle 1).
   task automatic send(input logic [31:0] a, input logic [31:0] b, input logic [1:0] c);
      req_valid   = 1'b1;
      req_op1     = a;
      req_op2     = b;
      req_control = c;
      @(posedge clock);
      #1;
      req_valid = 1'b0;
   endtask

   // Called in cycle 1; returns in the cycle where rsp_valid is first seen.
   task automatic wait_rsp(output int cyc, output int st_first, output int st_cnt);
      cyc      = 1;
      st_first = 0;
      st_cnt   = 0;
      while (!rsp_valid && cyc < 400) begin
         if (alu_start) begin
            if (st_first == 0) st_first = cyc;
            st_cnt++;
         end
         @(posedge clock);
         #1;
         cyc++;
      end
      chk("rsp_seen", {63'b0, rsp_valid}, 64'd1);
   endtask

   // With rsp_ready high the response drains in one edge.
   task automatic drain(input string tag);
      @(posedge clock);
      #1;
      chk({tag, "_vld_low"}, {63'b0, rsp_valid}, 64'd0);
      chk({tag, "_rdy_high"}, {63'b0, req_ready}, 64'd1);
   endtask

   int cyc, sf, sc;

   initial begin
      reset       = 1'b1;
      req_valid   = 1'b0;
      req_op1     = '0;
      req_op2     = '0;
      req_control = '0;
      rsp_ready   = 1'b1;
      #12;
      chk("rst_req_ready", {63'b0, req_ready}, 64'd1);
      chk("rst_rsp_valid", {63'b0, rsp_valid}, 64'd0);
      chk("rst_busy", {63'b0, busy}, 64'd0);
      chk("rst_start", {63'b0, alu_start}, 64'd0);
      chk("rst_enable", {63'b0, alu_enable}, 64'd0);
      chk("rst_op1", {32'b0, alu_op1}, 64'd0);
      chk("rst_result", {32'b0, rsp_result}, 64'd0);
      reset = 1'b0;
      @(posedge clock);
      #1;

      // add
      done_mode = 0;
      send(32'd5, 32'd3, 2'd0);
      chk("add_busy", {63'b0, busy}, 64'd1);
      chk("add_enable", {63'b0, alu_enable}, 64'd1);
      wait_rsp(cyc, sf, sc);
      chk("add_lat", 64'(cyc), 64'd6);
      chk("add_start_cyc", 64'(sf), 64'd2);
      chk("add_start_len", 64'(sc), 64'd1);
      chk("add_res", {32'b0, rsp_result}, 64'h8);
      chk("add_ext", {32'b0, rsp_extra}, 64'h0);
      chk("add_to", {63'b0, rsp_timeout}, 64'd0);
      chk("add_ctl", {62'b0, rsp_control}, 64'd0);
      chk("add_en_resp", {63'b0, alu_enable}, 64'd0);
      drain("add");

      // sub with borrow
      send(32'd3, 32'd5, 2'd1);
      wait_rsp(cyc, sf, sc);
      chk("sub_lat", 64'(cyc), 64'd6);
      chk("sub_res", {32'b0, rsp_result}, 64'hFFFF_FFFE);
      chk("sub_ext", {32'b0, rsp_extra}, 64'h0);
      chk("sub_op2", {32'b0, alu_op2}, 64'd5);
      chk("sub_ctl", {62'b0, rsp_control}, 64'd1);
      drain("sub");

      // mul, stale done during masked cycles, real done 40 cycles after start
      done_mode = 1;
      send(32'h1_0000, 32'h1_0000, 2'd2);
      wait_rsp(cyc, sf, sc);
      chk("mul_lat", 64'(cyc), 64'd43);
      chk("mul_res", {32'b0, rsp_result}, 64'h0);
      chk("mul_ext", {32'b0, rsp_extra}, 64'h1);
      chk("mul_to", {63'b0, rsp_timeout}, 64'd0);
      drain("mul");

      // timeout on div
      done_mode = 2;
      send(32'd100, 32'd7, 2'd3);
      wait_rsp(cyc, sf, sc);
      chk("to_lat", 64'(cyc), 64'd259);
      chk("to_flag", {63'b0, rsp_timeout}, 64'd1);
      chk("to_ctl", {62'b0, rsp_control}, 64'd3);
      drain("to");

      // backpressure
      done_mode = 0;
      rsp_ready = 1'b0;
      send(32'd7, 32'd9, 2'd0);
      wait_rsp(cyc, sf, sc);
      chk("bp_lat", 64'(cyc), 64'd6);
      req_valid   = 1'b1;
      req_op1     = 32'd100;
      req_op2     = 32'd1;
      req_control = 2'd0;
      for (int i = 0; i < 10; i++) begin
         @(posedge clock);
         #1;
         chk("bp_valid", {63'b0, rsp_valid}, 64'd1);
         chk("bp_res", {32'b0, rsp_result}, 64'd16);
         chk("bp_req_ready", {63'b0, req_ready}, 64'd0);
         chk("bp_op1", {32'b0, alu_op1}, 64'd7);
      end
      rsp_ready = 1'b1;
      @(posedge clock);
      #1;
      chk("bp_rel_vld", {63'b0, rsp_valid}, 64'd0);
      chk("bp_rel_rdy", {63'b0, req_ready}, 64'd1);
      @(posedge clock);
      #1;
      req_valid = 1'b0;
      chk("bp_next_busy", {63'b0, busy}, 64'd1);
      chk("bp_next_op1", {32'b0, alu_op1}, 64'd100);
      wait_rsp(cyc, sf, sc);
      chk("bp_next_lat", 64'(cyc), 64'd6);
      chk("bp_next_res", {32'b0, rsp_result}, 64'd101);
      drain("bp");

      // reset during START
      send(32'd1, 32'd2, 2'd0);
      @(posedge clock);
      #1;
      chk("mid_start_hi", {63'b0, alu_start}, 64'd1);
      reset = 1'b1;
      #1;
      chk("mid_start", {63'b0, alu_start}, 64'd0);
      chk("mid_enable", {63'b0, alu_enable}, 64'd0);
      chk("mid_req_ready", {63'b0, req_ready}, 64'd1);
      chk("mid_rsp_valid", {63'b0, rsp_valid}, 64'd0);
      #2;
      reset = 1'b0;
      send(32'd2, 32'd2, 2'd0);
      wait_rsp(cyc, sf, sc);
      chk("post_rst_lat", 64'(cyc), 64'd6);
      chk("post_rst_res", {32'b0, rsp_result}, 64'd4);
      drain("post");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
